// File: rtl/aes_pkg.sv
`default_nettype none
// aes_pkg: state/byte types and GF(2^8) helpers shared by the AES linear round.
// Revision: 1.0
package aes_pkg;

  typedef logic [127:0] state_t;
  typedef logic [7:0]   byte_t;

  localparam int ROW_W = 32;

  // MSB index of row r inside a row-major 128-bit state
  function automatic int row_msb(input int r);
    return 127 - ROW_W * r;
  endfunction

  function automatic byte_t xtime(input byte_t b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  function automatic byte_t gmul(input byte_t b, input byte_t k);
    byte_t acc;
    byte_t p;
    acc = '0;
    p   = b;
    for (int i = 0; i < 8; i++) begin
      if (k[i]) acc = acc ^ p;
      p = xtime(p);
    end
    return acc;
  endfunction

  function automatic logic [31:0] rotl_bytes(input logic [31:0] w, input int n);
    return (w << (8 * n)) | (w >> (32 - 8 * n));
  endfunction

  function automatic state_t sr_fwd(input state_t s);
    state_t o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      o[row_msb(r) -: 32] = rotl_bytes(s[row_msb(r) -: 32], r);
    end
    return o;
  endfunction

  function automatic state_t sr_inv(input state_t s);
    state_t o;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      o[row_msb(r) -: 32] = rotl_bytes(s[row_msb(r) -: 32], (4 - r) % 4);
    end
    return o;
  endfunction

  // Circulant column multiply: out_r = k0*a_r ^ k1*a_(r+1) ^ k2*a_(r+2) ^ k3*a_(r+3)
  function automatic logic [31:0] mix_col(input logic [31:0] col, input byte_t k0,
                                          input byte_t k1, input byte_t k2, input byte_t k3);
    logic [31:0] o;
    logic [31:0] rc;
    o = '0;
    for (int r = 0; r < 4; r++) begin
      rc = rotl_bytes(col, r);
      o[31 - 8 * r -: 8] = gmul(rc[31:24], k0) ^ gmul(rc[23:16], k1) ^
                           gmul(rc[15:8], k2)  ^ gmul(rc[7:0], k3);
    end
    return o;
  endfunction

  function automatic logic [31:0] mix_col_fwd(input logic [31:0] col);
    return mix_col(col, 8'h02, 8'h03, 8'h01, 8'h01);
  endfunction

  function automatic logic [31:0] mix_col_inv(input logic [31:0] col);
    return mix_col(col, 8'h0e, 8'h0b, 8'h0d, 8'h09);
  endfunction

endpackage
`default_nettype wire

// File: rtl/aes_mix_columns.sv
`default_nettype none
// aes_mix_columns: combinational MixColumns / InvMixColumns over a row-major state.
// Revision: 1.0
module aes_mix_columns
  import aes_pkg::*;
(
  input  state_t state_i,
  input  logic   dec_i,
  output state_t state_o
);

  for (genvar c = 0; c < 4; c++) begin : g_col
    logic [31:0] col;
    logic [31:0] col_mix;

    // Gather column c from the four rows, mix, and scatter back
    assign col = {state_i[127 - 8 * c -: 8],
                  state_i[127 - ROW_W - 8 * c -: 8],
                  state_i[127 - 2 * ROW_W - 8 * c -: 8],
                  state_i[127 - 3 * ROW_W - 8 * c -: 8]};

    assign col_mix = dec_i ? mix_col_inv(col) : mix_col_fwd(col);

    assign state_o[127 - 8 * c -: 8]             = col_mix[31:24];
    assign state_o[127 - ROW_W - 8 * c -: 8]     = col_mix[23:16];
    assign state_o[127 - 2 * ROW_W - 8 * c -: 8] = col_mix[15:8];
    assign state_o[127 - 3 * ROW_W - 8 * c -: 8] = col_mix[7:0];
  end

endmodule
`default_nettype wire

// File: rtl/aes_lin_round.sv
`default_nettype none
// aes_lin_round: elastic pipelined ShiftRows -> MixColumns -> AddRoundKey with tag sideband.
// Revision: 1.0
module aes_lin_round
  import aes_pkg::*;
#(
  parameter int STAGES  = 2,
  parameter bit KEY_ADD = 1'b1,
  parameter int TAG_W   = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [127:0]     in_data,
  input  logic [127:0]     in_key,
  input  logic             in_dec,
  input  logic             in_last,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [127:0]     out_data,
  output logic [TAG_W-1:0] out_tag
);

  if (STAGES < 1 || STAGES > 4) begin : g_bad_stages
    $error("aes_lin_round: STAGES must be in 1..4");
  end
  if (TAG_W < 1 || TAG_W > 16) begin : g_bad_tag_w
    $error("aes_lin_round: TAG_W must be in 1..16");
  end

  logic [STAGES-1:0] v_q;
  logic [STAGES-1:0] adv;
  logic [STAGES-1:0] load;
  state_t            data_q [STAGES];
  state_t            data_d [STAGES];
  logic [TAG_W-1:0]  tag_q  [STAGES];
  logic [TAG_W-1:0]  tag_d  [STAGES];
  state_t            key_q;
  logic              dec_q;
  logic              last_q;
  logic              take;

  state_t sr_out;
  state_t rnd_src;
  state_t mc_out;
  state_t rnd_out;
  state_t key_use;
  logic   dec_use;
  logic   last_use;

  // A stage may move when the output is accepted or any stage downstream of it is empty
  always_comb begin : handshake
    logic room;
    room = out_ready;
    for (int i = STAGES - 1; i >= 0; i--) begin
      adv[i] = v_q[i] & room;
      room   = room | ~v_q[i];
    end
    in_ready = room;
  end

  assign take = in_valid & in_ready;

  assign sr_out = in_dec ? sr_inv(in_data) : sr_fwd(in_data);

  // With a single stage the whole round is computed ahead of the only register
  assign rnd_src  = (STAGES == 1) ? sr_out  : data_q[0];
  assign dec_use  = (STAGES == 1) ? in_dec  : dec_q;
  assign last_use = (STAGES == 1) ? in_last : last_q;
  assign key_use  = (STAGES == 1) ? in_key  : key_q;

  aes_mix_columns u_mix (
    .state_i (rnd_src),
    .dec_i   (dec_use),
    .state_o (mc_out)
  );

  assign rnd_out = (last_use ? rnd_src : mc_out) ^ (KEY_ADD ? key_use : '0);

  always_comb begin
    load[0]   = take;
    data_d[0] = (STAGES == 1) ? rnd_out : sr_out;
    tag_d[0]  = in_tag;
    for (int i = 1; i < STAGES; i++) begin
      load[i]   = adv[i-1];
      data_d[i] = (i == 1) ? rnd_out : data_q[i-1];
      tag_d[i]  = tag_q[i-1];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      v_q    <= '0;
      key_q  <= '0;
      dec_q  <= 1'b0;
      last_q <= 1'b0;
      for (int i = 0; i < STAGES; i++) begin
        data_q[i] <= '0;
        tag_q[i]  <= '0;
      end
    end else begin
      for (int i = 0; i < STAGES; i++) begin
        if (load[i]) begin
          v_q[i]    <= 1'b1;
          data_q[i] <= data_d[i];
          tag_q[i]  <= tag_d[i];
        end else if (adv[i]) begin
          v_q[i] <= 1'b0;
        end
      end
      if (take) begin
        key_q  <= in_key;
        dec_q  <= in_dec;
        last_q <= in_last;
      end
    end
  end

  assign out_valid = v_q[STAGES-1];
  assign out_data  = data_q[STAGES-1];
  assign out_tag   = tag_q[STAGES-1];

endmodule
`default_nettype wire
